// File: rtl/ctrl_pipe_pkg.sv
// Shared constants and helpers for the control pipeline register.
// Feature macro: CTRL_PIPE_SKID_EN (adds a skid entry).
package ctrl_pipe_pkg;

  localparam int CP_WIDTH   = 32;
  localparam int CP_NUM_SRC = 3;
  localparam int SQ_W       = 16;

  typedef logic [SQ_W-1:0] sq_cnt_t;

  // Saturating add so the squash count sticks at all-ones.
  function automatic sq_cnt_t sq_sat_add(
    input sq_cnt_t    a,
    input logic [1:0] b
  );
    logic [SQ_W:0] s;
    s = {1'b0, a} + {{(SQ_W-1){1'b0}}, b};
    return s[SQ_W] ? '1 : s[SQ_W-1:0];
  endfunction

endpackage

// File: rtl/ctrl_pipe_reg_nmux.sv
// N-input payload selector; out-of-range selects fall back to input 0.
// Used by ctrl_pipe_reg (feature macro CTRL_PIPE_SKID_EN lives there).
module nmux #(
  parameter  int W  = 8,
  parameter  int N  = 2,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N*W-1:0] i_data,
  input  logic [SW-1:0]  i_sel,
  output logic [W-1:0]   o_data
);

  always_comb begin
    o_data = i_data[W-1:0];
    for (int k = 1; k < N; k++) begin
      if (i_sel == SW'(k)) begin
        o_data = i_data[k*W +: W];
      end
    end
  end

endmodule

// File: rtl/ctrl_pipe_reg.sv
// Valid/ready pipeline register with source mux, flush and squash count.
// Define CTRL_PIPE_SKID_EN for a registered-ready skid entry.
module ctrl_pipe_reg
  import ctrl_pipe_pkg::*;
#(
  parameter  int WIDTH   = CP_WIDTH,
  parameter  int NUM_SRC = CP_NUM_SRC,
  localparam int SW      = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC*WIDTH-1:0] in_data,
  input  logic [SW-1:0]            in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [SQ_W-1:0]          squash_cnt
);

  logic [WIDTH-1:0] w_sel_data;
  logic             w_in_xfer;
  logic             w_out_stall;
  logic [1:0]       w_drop;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  sq_cnt_t          r_squash_cnt;

  nmux #(
    .W (WIDTH),
    .N (NUM_SRC)
  ) u_nmux (
    .i_data (in_data),
    .i_sel  (in_sel),
    .o_data (w_sel_data)
  );

  assign w_in_xfer   = in_valid && in_ready;
  assign w_out_stall = r_out_valid && !out_ready;

`ifdef CTRL_PIPE_SKID_EN
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;

  assign in_ready = !flush && !r_skid_valid;
  assign w_drop   = {1'b0, w_out_stall} + {1'b0, r_skid_valid};

  // Skid drains into out before any new input, keeping order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (!w_out_stall) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_skid_valid <= 1'b0;
        r_skid_data  <= '0;
      end else if (w_in_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
      end else begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
      end
    end else if (w_in_xfer) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_sel_data;
    end
  end
`else
  assign in_ready = !flush && (!r_out_valid || out_ready);
  assign w_drop   = {1'b0, w_out_stall};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_in_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end
  end
`endif

  // An entry leaving on the flush edge is delivered, not squashed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_squash_cnt <= '0;
    end else if (flush) begin
      r_squash_cnt <= sq_sat_add(r_squash_cnt, w_drop);
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign squash_cnt = r_squash_cnt;

endmodule
